// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences one MIPS-style TLB instruction (TLBP/TLBR/TLBWI/TLBWR)
// offered from writeback. It waits for outstanding memory traffic to drain, then
// either probes the TLB or issues a one-cycle read/write strobe to CP0. It finishes
// by requesting a refetch from the instruction after the TLB op.
// All strobes are registered: each one is computed from the next state, so it is
// high exactly during the cycle the FSM spends in the matching state.
module tlb_op_ctrl #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic [1:0]              op_type,
  input  logic [31:0]             op_pc,
  output logic                    op_ready,
  input  logic                    flush,
  input  logic                    mem_busy,
  input  logic [18:0]             entry_hi_vpn2,
  input  logic [7:0]              entry_hi_asid,
  output logic                    s_valid,
  output logic [18:0]             s_vpn2,
  output logic [7:0]              s_asid,
  input  logic                    s_found,
  input  logic [TLBNUM_WIDTH-1:0] s_index,
  output logic                    tlbp,
  output logic [TLBNUM_WIDTH:0]   tlbp_result,
  output logic                    tlbr,
  output logic                    we,
  output logic                    tlbwr,
  output logic                    refetch,
  output logic [31:0]             refetch_pc,
  output logic                    busy
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PROBE   = 3'd2,
    ST_RESULT  = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_REFETCH = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_op_type;
  logic [31:0]             r_op_pc;
  logic                    r_op_ready;
  logic                    r_busy;
  logic                    r_s_valid;
  logic                    r_tlbp;
  logic                    r_tlbr;
  logic                    r_we;
  logic                    r_tlbwr;
  logic                    r_refetch;
  logic [31:0]             r_refetch_pc;
  logic [TLBNUM_WIDTH:0]   r_tlbp_result;
  logic                    w_accept;
  logic [TLBNUM_WIDTH:0]   w_probe_result;

  // An op is taken only in IDLE and only when it is not being cancelled.
  assign w_accept       = (r_state == ST_IDLE) && op_valid && !flush;
  // TLB search result arrives during RESULT; top bit flags a miss.
  assign w_probe_result = {~s_found, s_index};

  // Next-state logic: drain memory, then probe or commit, then refetch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          w_next = ST_IDLE;
        end else if (!mem_busy) begin
          if (r_op_type == OP_TLBP) begin
            w_next = ST_PROBE;
          end else begin
            w_next = ST_COMMIT;
          end
        end else begin
          w_next = ST_DRAIN;
        end
      end
      ST_PROBE: begin
        if (flush) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESULT;
        end
      end
      // Once the op reaches RESULT/COMMIT it has committed; flush is ignored.
      ST_RESULT:  w_next = ST_REFETCH;
      ST_COMMIT:  w_next = ST_REFETCH;
      ST_REFETCH: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register plus registered strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_s_valid  <= 1'b0;
      r_tlbp     <= 1'b0;
      r_tlbr     <= 1'b0;
      r_we       <= 1'b0;
      r_tlbwr    <= 1'b0;
      r_refetch  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_op_ready <= (w_next == ST_IDLE);
      r_busy     <= (w_next != ST_IDLE);
      r_s_valid  <= (w_next == ST_PROBE);
      r_tlbp     <= (w_next == ST_RESULT);
      r_tlbr     <= (w_next == ST_COMMIT) && (r_op_type == OP_TLBR);
      r_we       <= (w_next == ST_COMMIT) && r_op_type[1];
      r_tlbwr    <= (w_next == ST_COMMIT) && (r_op_type == OP_TLBWR);
      r_refetch  <= (w_next == ST_REFETCH);
    end
  end

  // Latch the accepted op so later inputs cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_type <= 2'b00;
      r_op_pc   <= 32'h0000_0000;
    end else if (w_accept) begin
      r_op_type <= op_type;
      r_op_pc   <= op_pc;
    end else begin
      r_op_type <= r_op_type;
      r_op_pc   <= r_op_pc;
    end
  end

  // Keep the probe result for CP0 until the next probe completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tlbp_result <= '0;
    end else if (r_state == ST_RESULT) begin
      r_tlbp_result <= w_probe_result;
    end else begin
      r_tlbp_result <= r_tlbp_result;
    end
  end

  // Restart address is loaded on entry to REFETCH and held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refetch_pc <= 32'h0000_0000;
    end else if (w_next == ST_REFETCH) begin
      r_refetch_pc <= r_op_pc + 32'd4;
    end else begin
      r_refetch_pc <= r_refetch_pc;
    end
  end

  assign op_ready    = r_op_ready;
  assign busy        = r_busy;
  assign s_valid     = r_s_valid;
  assign s_vpn2      = entry_hi_vpn2;
  assign s_asid      = entry_hi_asid;
  assign tlbp        = r_tlbp;
  // During RESULT the fresh search outcome is forwarded so it lines up with tlbp.
  assign tlbp_result = (r_state == ST_RESULT) ? w_probe_result : r_tlbp_result;
  assign tlbr        = r_tlbr;
  assign we          = r_we;
  assign tlbwr       = r_tlbwr;
  assign refetch     = r_refetch;
  assign refetch_pc  = r_refetch_pc;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl. Inputs are driven 1 ns after the rising edge
// and outputs are checked at that same point, away from the active edge.
module tb_tlb_op_ctrl;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        op_ready;
  logic        flush;
  logic        mem_busy;
  logic [18:0] entry_hi_vpn2;
  logic [7:0]  entry_hi_asid;
  logic        s_valid;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic        tlbp;
  logic [4:0]  tlbp_result;
  logic        tlbr;
  logic        we;
  logic        tlbwr;
  logic        refetch;
  logic [31:0] refetch_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .op_pc(op_pc), .op_ready(op_ready), .flush(flush), .mem_busy(mem_busy),
    .entry_hi_vpn2(entry_hi_vpn2), .entry_hi_asid(entry_hi_asid),
    .s_valid(s_valid), .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .tlbp(tlbp),
    .tlbp_result(tlbp_result), .tlbr(tlbr), .we(we), .tlbwr(tlbwr),
    .refetch(refetch), .refetch_pc(refetch_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {s_valid, tlbp, tlbr, we, tlbwr, refetch}
  task automatic chk_strobes(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, s_valid, tlbp, tlbr, we, tlbwr, refetch}, {26'd0, exp});
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_pc = 32'h0;
    flush = 1'b0; mem_busy = 1'b0; entry_hi_vpn2 = 19'h12345;
    entry_hi_asid = 8'hA5; s_found = 1'b0; s_index = 4'd0;
    step(); step();
    // Reset state
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_strobes("rst_strobes", 6'b000000);
    chk("rst_tlbp_result", {27'd0, tlbp_result}, 32'd0);
    chk("rst_refetch_pc", refetch_pc, 32'h0);
    reset = 1'b0;
    step();

    // TLBP hit, index 5
    op_valid = 1'b1; op_type = 2'b00; op_pc = 32'h8000_1000;
    s_found = 1'b1; s_index = 4'd5;
    step();                        // T+1 DRAIN
    op_valid = 1'b0;
    chk("p1_busy", {31'd0, busy}, 32'd1);
    chk("p1_ready", {31'd0, op_ready}, 32'd0);
    chk_strobes("p1_t1", 6'b000000);
    step();                        // T+2 PROBE
    chk_strobes("p1_t2", 6'b100000);
    chk("p1_vpn2", {13'd0, s_vpn2}, 32'h12345);
    chk("p1_asid", {24'd0, s_asid}, 32'hA5);
    step();                        // T+3 RESULT
    chk_strobes("p1_t3", 6'b010000);
    chk("p1_result", {27'd0, tlbp_result}, 32'h05);
    step();                        // T+4 REFETCH
    s_found = 1'b0; s_index = 4'd9;
    chk_strobes("p1_t4", 6'b000001);
    chk("p1_refetch_pc", refetch_pc, 32'h8000_1004);
    chk("p1_result_held", {27'd0, tlbp_result}, 32'h05);
    step();                        // IDLE
    chk_strobes("p1_idle", 6'b000000);
    chk("p1_idle_ready", {31'd0, op_ready}, 32'd1);
    chk("p1_pc_held", refetch_pc, 32'h8000_1004);

    // TLBP miss, index 3
    op_valid = 1'b1; op_type = 2'b00; op_pc = 32'h0000_2000;
    s_found = 1'b0; s_index = 4'd3;
    step();
    op_valid = 1'b0;
    step(); step();
    chk_strobes("p2_t3", 6'b010000);
    chk("p2_result", {27'd0, tlbp_result}, 32'h13);
    step();
    chk("p2_refetch_pc", refetch_pc, 32'h0000_2004);
    step();

    // TLBWR with memory busy for 4 cycles; op_valid during DRAIN is ignored
    op_valid = 1'b1; op_type = 2'b11; op_pc = 32'h0000_3000; mem_busy = 1'b1;
    step();
    op_type = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk_strobes("wr_drain", 6'b000000);
      chk("wr_drain_ready", {31'd0, op_ready}, 32'd0);
      if (i < 3) step();
    end
    op_valid = 1'b0; mem_busy = 1'b0;
    step();                        // COMMIT
    chk_strobes("wr_commit", 6'b000110);
    step();
    chk_strobes("wr_refetch", 6'b000001);
    chk("wr_refetch_pc", refetch_pc, 32'h0000_3004);
    step();
    chk_strobes("wr_idle", 6'b000000);

    // TLBWI flushed in DRAIN
    op_valid = 1'b1; op_type = 2'b10; op_pc = 32'h0000_4000; mem_busy = 1'b1;
    step();
    op_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; mem_busy = 1'b0;
    chk("wi_flush_ready", {31'd0, op_ready}, 32'd1);
    chk("wi_flush_busy", {31'd0, busy}, 32'd0);
    chk_strobes("wi_flush_s0", 6'b000000);
    step();
    chk_strobes("wi_flush_s1", 6'b000000);
    step();
    chk_strobes("wi_flush_s2", 6'b000000);
    chk("wi_flush_pc", refetch_pc, 32'h0000_3004);

    // op_valid with flush in IDLE is not accepted
    op_valid = 1'b1; op_type = 2'b01; flush = 1'b1;
    step();
    op_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    step();
    chk_strobes("idle_flush_s", 6'b000000);

    // TLBR at 0xFFFFFFFC with flush in COMMIT
    op_valid = 1'b1; op_type = 2'b01; op_pc = 32'hFFFF_FFFC;
    step();
    op_valid = 1'b0;
    step();                        // COMMIT
    chk_strobes("rd_commit", 6'b001000);
    flush = 1'b1;
    step();                        // REFETCH
    flush = 1'b0;
    chk_strobes("rd_refetch", 6'b000001);
    chk("rd_refetch_pc", refetch_pc, 32'h0000_0000);
    step();

    // Reset in PROBE discards the op
    op_valid = 1'b1; op_type = 2'b00; op_pc = 32'h0000_5000;
    s_found = 1'b1; s_index = 4'd7;
    step();
    op_valid = 1'b0;
    step();                        // PROBE
    chk_strobes("rs_probe", 6'b100000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_strobes("rs_after", 6'b000000);
    chk("rs_ready", {31'd0, op_ready}, 32'd1);
    chk("rs_result", {27'd0, tlbp_result}, 32'd0);
    step();
    chk_strobes("rs_after2", 6'b000000);
    chk("rs_ready2", {31'd0, op_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
